alu_arbiter: RTL

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/alu_arbiter.sv | 124 ++++++++++++
 1 files changed

// File: rtl/alu_arbiter.sv
// Two-requester round-robin front end for a shared ALU: grants one requester,
// issues its opcode/operands, waits (with timeout) for the result and returns it.
module alu_arbiter #(
  parameter int TIMEOUT = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req_0,
  input  logic               req_1,
  input  logic [7:0]         opcode_0,
  input  logic [7:0]         opcode_1,
  input  logic signed [7:0]  operand_A_0,
  input  logic signed [7:0]  operand_B_0,
  input  logic signed [7:0]  operand_A_1,
  input  logic signed [7:0]  operand_B_1,
  output logic               gnt_0,
  output logic               gnt_1,
  output logic               done_0,
  output logic               done_1,
  output logic signed [7:0]  result_out,
  output logic               carry_out,
  output logic               borrow_out,
  output logic               err_out,
  output logic               busy,
  output logic               alu_start,
  output logic [7:0]         alu_opcode,
  output logic signed [7:0]  alu_operand_A,
  output logic signed [7:0]  alu_operand_B,
  input  logic signed [7:0]  alu_result,
  input  logic               alu_carry,
  input  logic               alu_borrow,
  input  logic               alu_result_ready
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  localparam logic [7:0] LAST_CNT = 8'(TIMEOUT - 1);

  state_t     state;
  logic [7:0] wait_cnt;
  logic       last_gnt;
  logic       owner;
  logic       pick;

  // On a tie the requester that was not granted last wins.
  always_comb begin
    pick = (req_0 && req_1) ? ~last_gnt : req_1;
  end

  assign busy = (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      wait_cnt      <= 8'd0;
      last_gnt      <= 1'b1;
      owner         <= 1'b0;
      gnt_0         <= 1'b0;
      gnt_1         <= 1'b0;
      done_0        <= 1'b0;
      done_1        <= 1'b0;
      alu_start     <= 1'b0;
      alu_opcode    <= 8'd0;
      alu_operand_A <= 8'sd0;
      alu_operand_B <= 8'sd0;
      result_out    <= 8'sd0;
      carry_out     <= 1'b0;
      borrow_out    <= 1'b0;
      err_out       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_0 || req_1) begin
            owner         <= pick;
            alu_opcode    <= pick ? opcode_1    : opcode_0;
            alu_operand_A <= pick ? operand_A_1 : operand_A_0;
            alu_operand_B <= pick ? operand_B_1 : operand_B_0;
            gnt_0         <= ~pick;
            gnt_1         <= pick;
            alu_start     <= 1'b1;
            state         <= ISSUE;
          end
        end
        ISSUE: begin
          gnt_0     <= 1'b0;
          gnt_1     <= 1'b0;
          alu_start <= 1'b0;
          wait_cnt  <= 8'd0;
          state     <= WAIT;
        end
        WAIT: begin
          // A ready arriving on the timeout cycle still counts as success.
          if (alu_result_ready) begin
            result_out <= alu_result;
            carry_out  <= alu_carry;
            borrow_out <= alu_borrow;
            err_out    <= 1'b0;
            done_0     <= ~owner;
            done_1     <= owner;
            state      <= RESP;
          end else if (wait_cnt == LAST_CNT) begin
            result_out <= 8'sd0;
            carry_out  <= 1'b0;
            borrow_out <= 1'b0;
            err_out    <= 1'b1;
            done_0     <= ~owner;
            done_1     <= owner;
            state      <= RESP;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        RESP: begin
          done_0   <= 1'b0;
          done_1   <= 1'b0;
          last_gnt <= owner;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
